reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Architectural register file at the consuming end of the write-back interface: stores RegWBData
//  into register RegWBAddr when RegWBWE is high. Two combinational read ports feed decode.
//  Per-register pending-write scoreboard tracks in-flight results so decode can raise RAW/WAW stalls.
//  Address map: 0-31 GPR (r0 hardwired zero), 32-63 FPR (f0 = addr 32 is an ordinary register).
// PARAMETERS
//  DATA_W   32  register width
//  ADDR_W   6   register address width (2**ADDR_W registers)
//  CNT_W    2   pending-write counter width (max 2**CNT_W-1 in-flight writes per register)
// PORTS
//  clk         in   1       clock, all state updates on rising edge
//  reset_n     in   1       reset; one clock; reset is asynchronous and active-low
//  RegWBWE     in   1       write-back write enable
//  RegWBAddr   in   6       write-back destination
//  RegWBData   in   32      write-back data
//  RsAddr      in   6       read port A address
//  RtAddr      in   6       read port B address
//  RsData      out  32      read port A data (combinational)
//  RtData      out  32      read port B data (combinational)
//  IssueWE     in   1       instruction leaving decode will write IssueDst
//  IssueDst    in   6       destination of issuing instruction
//  Flush       in   1       clear all pending counters (pipeline flush)
//  RsBusy      out  1       pending write outstanding on RsAddr
//  RtBusy      out  1       pending write outstanding on RtAddr
//  DstFull     out  1       counter of IssueDst saturated; decode must not assert IssueWE
//  SbError     out  1       sticky: issue at saturation or write-back to a zero counter
// BEHAVIOUR
//  - Reset (reset_n=0, async): all registers 0, all counters 0, SbError 0; hence RsData/RtData=0,
//    RsBusy/RtBusy/DstFull=0. Reset mid-operation discards in-flight state immediately.
//  - Write: on clk edge, RegWBWE && RegWBAddr!=0 -> reg[RegWBAddr]<=RegWBData. Writes to 0 dropped.
//  - Read: RsData = (RsAddr==0) ? 0 : (RegWBWE && RegWBAddr==RsAddr) ? RegWBData : reg[RsAddr];
//    same for Rt. Write-back bypass is zero-latency; read latency 0 cycles.
//  - Counter update per register i (i!=0), each edge:
//      inc = IssueWE && IssueDst==i && !cnt_full;  dec = RegWBWE && RegWBAddr==i && cnt!=0
//      inc&dec -> unchanged; inc -> +1; dec -> -1. Flush -> all counters 0 (overrides inc/dec;
//      register data write on the same edge still occurs).
//  - Register 0 counter is constant 0; IssueWE to 0 and writes to 0 ignored, never busy.
//  - RsBusy = cnt[RsAddr]!=0 && !(RegWBWE && RegWBAddr==RsAddr && cnt[RsAddr]==1);
//    i.e. the last outstanding write arriving this cycle is bypassed, not stalled. Same for Rt.
//  - DstFull = cnt[IssueDst]==2**CNT_W-1 (combinational); a decrement to the same reg in the same
//    cycle does not clear DstFull.
//  - Saturation: IssueWE while DstFull -> counter unchanged, SbError<=1.
//  - Underflow: RegWBWE to reg i!=0 with cnt[i]==0 -> data written, counter stays 0, SbError<=1.
//  - After Flush, late write-backs of flushed instructions update data and raise no SbError? No:
//    they find cnt==0 and set SbError; write-back stage squashes RegWBWE for flushed instructions.
//  - SbError cleared only by reset.
// STRUCTURE
//  - Shared package/constants: ZERO_REG=0, FPR_BASE=32, DATA_W, ADDR_W, CNT_W defaults.
//  - Sub-module pend_cnt (CNT_W saturating up/down counter with inc, dec, clr, full, nz outputs),
//    generated for registers 1..63; register 0 tied off.
//  - Storage: flat 64x32 array of flops with async clear; read muxes + bypass in top.
// TESTING
//  1 Reset: reset_n low mid-run after writes -> RsData=RtData=0 all addrs, busy/DstFull/SbError 0.
//  2 Write/read/bypass: WB r5=0xDEADBEEF; same cycle RsAddr=5 -> RsData=0xDEADBEEF; next cycle
//    RtAddr=5 -> 0xDEADBEEF; WB r0=0x1234 -> RsAddr=0 reads 0; WB addr 32 -> f0 reads back.
//  3 Scoreboard RAW: IssueWE r7; next cycle RsAddr=7 -> RsBusy=1; WB r7 -> RsBusy=0 that cycle,
//    RsData=WB data.
//  4 WAW/saturation: 3 issues to r9 -> DstFull=1; 4th IssueWE -> SbError=1, count stays 3;
//    3 WBs -> RtBusy drops only on 3rd.
//  5 Simultaneous: IssueWE r4 and WB r4 with cnt=1 -> cnt stays 1, RsBusy for r4 remains 1 next cycle.
//  6 Flush: 2 pending on r3, r12; Flush -> both busy 0 next cycle; stray WB r3 -> data written,
//    SbError=1.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the architectural register file and its scoreboard.
// Latency: n/a (constants only).
// Backpressure: n/a.
package reg_file_sb_pkg;
  localparam int DATA_W   = 32;  // register width
  localparam int ADDR_W   = 6;   // 2**ADDR_W registers
  localparam int CNT_W    = 2;   // pending-write counter width
  localparam int ZERO_REG = 0;   // GPR r0, hardwired zero
  localparam int FPR_BASE = 32;  // f0; an ordinary writable register
endpackage

// File: rtl/reg_file_sb_pend_cnt.sv
// Per-register pending-write counter: saturating up/down, clear overrides.
// Latency: count updates on the clock edge; full/nz reflect the current count.
// Backpressure: increments at saturation and decrements at zero are ignored.
// Ports: clk, reset_n (async active-low), inc/dec requests, clr (flush),
//        cnt (current count), full (count at max), nz (count non-zero).
module pend_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             nz
);
  logic incOk;
  logic decOk;

  assign full  = &cnt;
  assign nz    = |cnt;
  assign incOk = inc && !full;
  assign decOk = dec && nz;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (incOk && !decOk) begin
      cnt <= cnt + 1'b1;
    end else if (decOk && !incOk) begin
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// Register file (r0 = 0) with write-back bypass and per-register pending-write scoreboard.
// Latency: reads and busy/full flags are combinational; writes and counts update on clk.
// Backpressure: DstFull tells decode to hold issue; violations set sticky SbError.
// Ports: clk, reset_n; write-back RegWBWE/RegWBAddr/RegWBData; read RsAddr/RtAddr -> RsData/RtData;
//        issue IssueWE/IssueDst, Flush; status RsBusy, RtBusy, DstFull, SbError.
module reg_file_sb #(
  parameter int DATA_W = reg_file_sb_pkg::DATA_W,
  parameter int ADDR_W = reg_file_sb_pkg::ADDR_W,
  parameter int CNT_W  = reg_file_sb_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              RegWBWE,
  input  logic [ADDR_W-1:0] RegWBAddr,
  input  logic [DATA_W-1:0] RegWBData,
  input  logic [ADDR_W-1:0] RsAddr,
  input  logic [ADDR_W-1:0] RtAddr,
  output logic [DATA_W-1:0] RsData,
  output logic [DATA_W-1:0] RtData,
  input  logic              IssueWE,
  input  logic [ADDR_W-1:0] IssueDst,
  input  logic              Flush,
  output logic              RsBusy,
  output logic              RtBusy,
  output logic              DstFull,
  output logic              SbError
);
  import reg_file_sb_pkg::*;

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);

  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  cnt  [NREG];
  logic [NREG-1:0]   cntFull;
  logic [NREG-1:0]   cntNz;
  logic              wbLive;

  // Writes to r0 are dropped everywhere: data, bypass and scoreboard.
  assign wbLive = RegWBWE && (RegWBAddr != ZADDR);

  // Register 0 never has anything in flight.
  assign cnt[0]     = '0;
  assign cntFull[0] = 1'b0;
  assign cntNz[0]   = 1'b0;

  for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
    pend_cnt #(.CNT_W(CNT_W)) u_pend (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (IssueWE && (IssueDst == ADDR_W'(gi))),
      .dec     (RegWBWE && (RegWBAddr == ADDR_W'(gi))),
      .clr     (Flush),
      .cnt     (cnt[gi]),
      .full    (cntFull[gi]),
      .nz      (cntNz[gi])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wbLive) begin
      regs[RegWBAddr] <= RegWBData;
    end
  end

  // Sticky error: issue against a saturated counter, or a write-back nobody was waiting for.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      SbError <= 1'b0;
    end else if ((IssueWE && DstFull) || (wbLive && !cntNz[RegWBAddr])) begin
      SbError <= 1'b1;
    end
  end

  // Same-cycle write-back is forwarded so decode never sees stale data.
  assign RsData = (RsAddr == ZADDR) ? '0 :
                  (RegWBWE && RegWBAddr == RsAddr) ? RegWBData : regs[RsAddr];
  assign RtData = (RtAddr == ZADDR) ? '0 :
                  (RegWBWE && RegWBAddr == RtAddr) ? RegWBData : regs[RtAddr];

  // The last outstanding write landing this cycle is bypassed, so it does not stall.
  assign RsBusy = cntNz[RsAddr] &&
                  !(RegWBWE && RegWBAddr == RsAddr && cnt[RsAddr] == ONE);
  assign RtBusy = cntNz[RtAddr] &&
                  !(RegWBWE && RegWBAddr == RtAddr && cnt[RtAddr] == ONE);

  // Reflects the current count only; a same-cycle write-back does not relax it.
  assign DstFull = cntFull[IssueDst];
endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        RegWBWE = 1'b0;
  logic [5:0]  RegWBAddr = '0;
  logic [31:0] RegWBData = '0;
  logic [5:0]  RsAddr = '0;
  logic [5:0]  RtAddr = '0;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic        IssueWE = 1'b0;
  logic [5:0]  IssueDst = '0;
  logic        Flush = 1'b0;
  logic        RsBusy;
  logic        RtBusy;
  logic        DstFull;
  logic        SbError;

  int nTests = 0;
  int nFail  = 0;

  reg_file_sb dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .RegWBWE   (RegWBWE),
    .RegWBAddr (RegWBAddr),
    .RegWBData (RegWBData),
    .RsAddr    (RsAddr),
    .RtAddr    (RtAddr),
    .RsData    (RsData),
    .RtData    (RtData),
    .IssueWE   (IssueWE),
    .IssueDst  (IssueDst),
    .Flush     (Flush),
    .RsBusy    (RsBusy),
    .RtBusy    (RtBusy),
    .DstFull   (DstFull),
    .SbError   (SbError)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic [5:0]  rs;
    logic [5:0]  rt;
    logic        iw;
    logic [5:0]  id;
    logic        fl;
    logic [31:0] eRs;
    logic [31:0] eRt;
    logic        eRsB;
    logic        eRtB;
    logic        eFull;
    logic        eErr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic we, logic [5:0] wa, logic [31:0] wd, logic [5:0] rs,
                              logic [5:0] rt, logic iw, logic [5:0] id, logic fl,
                              logic [31:0] eRs, logic [31:0] eRt, logic eRsB, logic eRtB,
                              logic eFull, logic eErr);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.rs = rs; v.rt = rt;
    v.iw = iw; v.id = id; v.fl = fl;
    v.eRs = eRs; v.eRt = eRt; v.eRsB = eRsB; v.eRtB = eRtB; v.eFull = eFull; v.eErr = eErr;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [5:0] wa, input logic [31:0] wd,
                       input logic [5:0] rs, input logic [5:0] rt, input logic iw,
                       input logic [5:0] id, input logic fl);
    RegWBWE = we; RegWBAddr = wa; RegWBData = wd;
    RsAddr = rs; RtAddr = rt; IssueWE = iw; IssueDst = id; Flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 32'd0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0);
  endtask

  initial begin
    // Write/read/bypass, f0, RAW, simultaneous issue+WB, then WAW/saturation.
    add(0,  0, 32'h0,        5,  0, 0,  0, 0, 32'h0,        32'h0,        0, 0, 0, 0);
    add(0,  0, 32'h0,        5,  5, 1,  5, 0, 32'h0,        32'h0,        0, 0, 0, 0);
    add(1,  5, 32'hDEADBEEF, 5,  5, 0,  0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0);
    add(0,  0, 32'h0,        0,  5, 0,  0, 0, 32'h0,        32'hDEADBEEF, 0, 0, 0, 0);
    add(1,  0, 32'h1234,     0,  5, 1, 32, 0, 32'h0,        32'hDEADBEEF, 0, 0, 0, 0);
    add(0,  0, 32'h0,        0, 32, 0,  0, 0, 32'h0,        32'h0,        0, 1, 0, 0);
    add(1, 32, 32'hCAFEF00D, 32, 32, 0, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 0, 0);
    add(0,  0, 32'h0,        32, 5, 0,  0, 0, 32'hCAFEF00D, 32'hDEADBEEF, 0, 0, 0, 0);
    add(0,  0, 32'h0,        7,  0, 1,  7, 0, 32'h0,        32'h0,        0, 0, 0, 0);
    add(0,  0, 32'h0,        7,  0, 0,  0, 0, 32'h0,        32'h0,        1, 0, 0, 0);
    add(1,  7, 32'h77770001, 7,  0, 0,  0, 0, 32'h77770001, 32'h0,        0, 0, 0, 0);
    add(0,  0, 32'h0,        7,  7, 0,  0, 0, 32'h77770001, 32'h77770001, 0, 0, 0, 0);
    add(0,  0, 32'h0,        4,  0, 1,  4, 0, 32'h0,        32'h0,        0, 0, 0, 0);
    add(1,  4, 32'h44,       4,  0, 1,  4, 0, 32'h44,       32'h0,        0, 0, 0, 0);
    add(0,  0, 32'h0,        4,  0, 0,  0, 0, 32'h44,       32'h0,        1, 0, 0, 0);
    add(0,  0, 32'h0,        0,  9, 1,  9, 0, 32'h0,        32'h0,        0, 0, 0, 0);
    add(0,  0, 32'h0,        0,  9, 1,  9, 0, 32'h0,        32'h0,        0, 1, 0, 0);
    add(0,  0, 32'h0,        0,  9, 1,  9, 0, 32'h0,        32'h0,        0, 1, 0, 0);
    add(0,  0, 32'h0,        0,  9, 1,  9, 0, 32'h0,        32'h0,        0, 1, 1, 0);
    add(0,  0, 32'h0,        0,  9, 0,  9, 0, 32'h0,        32'h0,        0, 1, 1, 1);
    add(1,  9, 32'h99,       0,  9, 0,  9, 0, 32'h0,        32'h99,       0, 1, 1, 1);
    add(1,  9, 32'h9A,       0,  9, 0,  9, 0, 32'h0,        32'h9A,       0, 1, 0, 1);
    add(1,  9, 32'h9B,       0,  9, 0,  9, 0, 32'h0,        32'h9B,       0, 0, 0, 1);
    add(0,  0, 32'h0,        4,  9, 0,  9, 0, 32'h44,       32'h9B,       1, 0, 0, 1);

    // Reset state at power-up.
    idle();
    RsAddr = 6'd5; RtAddr = 6'd32;
    #2;
    chk("por.RsData", RsData, 32'h0);
    chk("por.RtData", RtData, 32'h0);
    chk("por.flags", {28'd0, RsBusy, RtBusy, DstFull, SbError}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].rs, vecs[k].rt,
            vecs[k].iw, vecs[k].id, vecs[k].fl);
      #1;
      chk($sformatf("v%0d.RsData", k), RsData, vecs[k].eRs);
      chk($sformatf("v%0d.RtData", k), RtData, vecs[k].eRt);
      chk($sformatf("v%0d.RsBusy", k), {31'd0, RsBusy}, {31'd0, vecs[k].eRsB});
      chk($sformatf("v%0d.RtBusy", k), {31'd0, RtBusy}, {31'd0, vecs[k].eRtB});
      chk($sformatf("v%0d.DstFull", k), {31'd0, DstFull}, {31'd0, vecs[k].eFull});
      chk($sformatf("v%0d.SbError", k), {31'd0, SbError}, {31'd0, vecs[k].eErr});
    end

    // Mid-run async reset: data, pending r4 and sticky error all cleared at once.
    @(negedge clk);
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    for (int a = 0; a < 64; a++) begin
      RsAddr = 6'(a); RtAddr = 6'(63 - a); IssueDst = 6'(a);
      #1;
      chk($sformatf("rst.a%0d", a),
          {RsData[15:0] | RsData[31:16] | RtData[15:0] | RtData[31:16],
           12'd0, RsBusy, RtBusy, DstFull, SbError}, 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Flush: two pending on r3 and r12, flush clears both, stray WB writes data and errors.
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      drive(1'b0, 6'd0, 32'd0, 6'd3, 6'd12, 1'b1, (n < 2) ? 6'd3 : 6'd12, 1'b0);
    end
    @(negedge clk);
    drive(1'b0, 6'd0, 32'd0, 6'd3, 6'd12, 1'b0, 6'd0, 1'b1);
    #1;
    chk("fl.busyBefore", {30'd0, RsBusy, RtBusy}, 32'h3);
    @(negedge clk);
    drive(1'b0, 6'd0, 32'd0, 6'd3, 6'd12, 1'b0, 6'd0, 1'b0);
    #1;
    chk("fl.busyAfter", {30'd0, RsBusy, RtBusy}, 32'h0);
    chk("fl.errBefore", {31'd0, SbError}, 32'h0);
    @(negedge clk);
    drive(1'b1, 6'd3, 32'h33, 6'd3, 6'd12, 1'b0, 6'd0, 1'b0);
    #1;
    chk("fl.strayBypass", RsData, 32'h33);
    @(negedge clk);
    idle();
    RsAddr = 6'd3;
    #1;
    chk("fl.strayData", RsData, 32'h33);
    chk("fl.strayErr", {31'd0, SbError}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
